// File: rtl/aud_rec_writer.sv
// aud_rec_writer: captures I2S left-channel samples from an ADC and writes them to sequential SRAM words
module aud_rec_writer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 21
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_bclk,
    input  logic              i_adclrck,
    input  logic              i_adcdat,
    input  logic [ADDR_W-1:0] i_max_addr,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_data,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic              o_done,
    output logic [2:0]        o_state
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam int CNT_W = $clog2(DATA_W + 2);

    logic [2:0]        bclk_q, lrck_q;
    logic [1:0]        dat_q;
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, end_q, end_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              bclk_rise, lrck_fall, last;

    // Two-flop synchronizers; bit 2 of bclk/lrck keeps the previous synchronized value for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bclk_q <= '0;
            lrck_q <= '0;
            dat_q  <= '0;
        end else begin
            bclk_q <= {bclk_q[1:0], i_bclk};
            lrck_q <= {lrck_q[1:0], i_adclrck};
            dat_q  <= {dat_q[0], i_adcdat};
        end
    end

    assign bclk_rise = bclk_q[1] & ~bclk_q[2];
    assign lrck_fall = ~lrck_q[1] & lrck_q[2];
    assign last      = addr_q == i_max_addr;

    // Next-state logic; cnt 0 means the I2S delay bit is still pending, cnt k+1 means k bits captured
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_WAIT;
                    addr_d  = '0;
                end
            end
            S_WAIT: begin
                if (i_stop) begin
                    state_d = S_DONE;
                    end_d   = addr_q;
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                end else if (lrck_fall) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    state_d = S_DONE;
                    end_d   = addr_q;
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                end else if (lrck_fall) begin
                    cnt_d = '0;
                end else if (bclk_rise) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q != '0) shreg_d = {shreg_q[DATA_W-2:0], dat_q[1]};
                    if (cnt_q == CNT_W'(DATA_W)) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last) begin
                    state_d = S_DONE;
                    end_d   = i_max_addr + 1'b1;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = i_stop ? S_DONE : i_pause ? S_PAUSE : S_WAIT;
                    if (i_stop) end_d = addr_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    state_d = S_DONE;
                    end_d   = addr_q;
                end else if (i_start) begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    state_d = S_WAIT;
                    addr_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and capture register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign o_sram_addr = addr_q;
    assign o_sram_data = shreg_q;
    assign o_sram_we   = state_q == S_WRITE;
    assign o_end_addr  = end_q;
    assign o_done      = state_q == S_DONE;
    assign o_state     = state_q;
endmodule

// File: tb/tb_aud_rec_writer.sv
// tb_aud_rec_writer: randomized I2S stimulus checked against a frame-level recording model
module tb_aud_rec_writer;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0, i_pause = 1'b0, i_stop = 1'b0;
    logic        i_bclk = 1'b0, i_adclrck = 1'b1, i_adcdat = 1'b0;
    logic [20:0] i_max_addr = 21'd1000;
    logic [20:0] o_sram_addr, o_end_addr;
    logic [15:0] o_sram_data;
    logic        o_sram_we, o_done;
    logic [2:0]  o_state;

    int errors = 0;
    int checks = 0;

    logic [20:0] got_a[$], exp_a[$];
    logic [15:0] got_d[$], exp_d[$];
    int          m_addr;
    logic [20:0] m_max;
    bit          m_done;
    logic [20:0] m_end;

    aud_rec_writer #(.DATA_W(16), .ADDR_W(21)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
        .i_bclk(i_bclk), .i_adclrck(i_adclrck), .i_adcdat(i_adcdat), .i_max_addr(i_max_addr),
        .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data), .o_sram_we(o_sram_we),
        .o_end_addr(o_end_addr), .o_done(o_done), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_sram_we) begin
            got_a.push_back(o_sram_addr);
            got_d.push_back(o_sram_data);
        end
    end

    task automatic send_frame(input logic [15:0] w, input int left_len, input int right_len);
        for (int k = 0; k < left_len + right_len; k++) begin
            i_bclk = 1'b0;
            i_adclrck = (k >= left_len);
            if (k >= left_len) i_adcdat = 1'($urandom & 1);
            else if (k >= 1 && k <= 16) i_adcdat = w[16-k];
            else i_adcdat = 1'b0;
            #50;
            i_bclk = 1'b1;
            #50;
        end
    endtask

    task automatic pulse(input int which);
        @(posedge i_clk); #1;
        if (which == 0) i_start = 1'b1; else if (which == 1) i_pause = 1'b1; else i_stop = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
    endtask

    task automatic model_frame(input logic [15:0] w);
        if (!m_done) begin
            exp_a.push_back(21'(m_addr));
            exp_d.push_back(w);
            if (21'(m_addr) == m_max) begin
                m_done = 1'b1;
                m_end = m_max + 21'd1;
            end else m_addr++;
        end
    endtask

    task automatic clear_lists();
        got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({o_state, o_sram_we, o_done, o_sram_addr, o_sram_data, o_end_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs state=%0d we=%0b done=%0b addr=%0d data=%h end=%0d expected all 0",
                     o_state, o_sram_we, o_done, o_sram_addr, o_sram_data, o_end_addr);
        end
        i_rst = 1'b0;
        pulse(1);
        pulse(2);
        repeat (5) @(posedge i_clk);
        #1;
        checks++;
        if (o_state !== 3'd0) begin
            errors++;
            $display("FAIL idle_hold state=%0d expected 0", o_state);
        end
    endtask

    task automatic test_basic();
        logic [15:0] w[5];
        w[0] = 16'hA5C3; w[1] = 16'h1234;
        for (int i = 2; i < 5; i++) w[i] = 16'($urandom);
        clear_lists();
        m_addr = 0; m_max = i_max_addr; m_done = 1'b0;
        pulse(0);
        for (int i = 0; i < 5; i++) begin
            send_frame(w[i], 18, 18);
            model_frame(w[i]);
        end
        checks++;
        if (got_a.size() != exp_a.size()) begin
            errors++;
            $display("FAIL basic_count got=%0d expected=%0d", got_a.size(), exp_a.size());
        end
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL basic_write%0d got addr=%0d data=%h expected addr=%0d data=%h",
                         i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
            end
        end
        checks++;
        if (o_state !== 3'd1) begin
            errors++;
            $display("FAIL basic_state state=%0d expected 1", o_state);
        end
    endtask

    task automatic test_full_memory();
        logic [15:0] w;
        pulse(2);
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_done !== 1'b1 || o_end_addr !== 21'(m_addr)) begin
            errors++;
            $display("FAIL stop_wait done=%0b end=%0d expected done=1 end=%0d", o_done, o_end_addr, m_addr);
        end
        clear_lists();
        i_max_addr = 21'd3;
        m_addr = 0; m_max = 21'd3; m_done = 1'b0;
        pulse(0);
        for (int i = 0; i < 5; i++) begin
            w = 16'($urandom);
            send_frame(w, 18, 18);
            model_frame(w);
        end
        checks++;
        if (got_a.size() != exp_a.size()) begin
            errors++;
            $display("FAIL full_count got=%0d expected=%0d", got_a.size(), exp_a.size());
        end
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL full_write%0d got addr=%0d data=%h expected addr=%0d data=%h",
                         i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
            end
        end
        checks++;
        if (o_done !== 1'b1 || o_end_addr !== m_end || o_state !== 3'd5) begin
            errors++;
            $display("FAIL full_done done=%0b end=%0d state=%0d expected done=1 end=%0d state=5",
                     o_done, o_end_addr, o_state, m_end);
        end
        i_max_addr = 21'd1000;
    endtask

    task automatic test_pause_resume();
        logic [15:0] w;
        clear_lists();
        m_addr = 0; m_max = i_max_addr; m_done = 1'b0;
        pulse(0);
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom);
            send_frame(w, 18, 18);
            model_frame(w);
        end
        fork
            send_frame(16'($urandom), 18, 18);
            begin
                repeat (80) @(posedge i_clk);
                #1;
                checks++;
                if (o_state !== 3'd2) begin
                    errors++;
                    $display("FAIL pause_pre state=%0d expected 2", o_state);
                end
                pulse(1);
            end
        join
        checks++;
        if (o_state !== 3'd4 || got_a.size() != 2) begin
            errors++;
            $display("FAIL pause_state state=%0d writes=%0d expected state=4 writes=2", o_state, got_a.size());
        end
        pulse(0);
        w = 16'($urandom);
        send_frame(w, 18, 18);
        model_frame(w);
        checks++;
        if (got_a.size() != 3 || got_a[got_a.size()-1] !== exp_a[2] || got_d[got_d.size()-1] !== exp_d[2]) begin
            errors++;
            $display("FAIL resume_write writes=%0d last addr=%0d data=%h expected 3 writes, addr=%0d data=%h",
                     got_a.size(), got_a[got_a.size()-1], got_d[got_d.size()-1], exp_a[2], exp_d[2]);
        end
    endtask

    task automatic test_stop_in_write();
        logic [15:0] w;
        bit seen;
        clear_lists();
        w = 16'($urandom);
        seen = 1'b0;
        fork
            send_frame(w, 18, 18);
            begin
                for (int c = 0; c < 1000 && !seen; c++) begin
                    @(negedge i_clk);
                    if (o_sram_we) seen = 1'b1;
                end
                if (seen) begin
                    i_stop = 1'b1;
                    @(posedge i_clk); #1;
                    i_stop = 1'b0;
                end
            end
        join
        model_frame(w);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stopwr_timeout we never seen expected=1");
        end
        checks++;
        if (got_a.size() != 1 || got_a[0] !== exp_a[0] || got_d[0] !== exp_d[0]) begin
            errors++;
            $display("FAIL stopwr_write writes=%0d addr=%0d data=%h expected 1 write addr=%0d data=%h",
                     got_a.size(), got_a[0], got_d[0], exp_a[0], exp_d[0]);
        end
        checks++;
        if (o_state !== 3'd5 || o_done !== 1'b1 || o_end_addr !== exp_a[0] + 21'd1) begin
            errors++;
            $display("FAIL stopwr_done state=%0d done=%0b end=%0d expected state=5 done=1 end=%0d",
                     o_state, o_done, o_end_addr, exp_a[0] + 21'd1);
        end
    endtask

    task automatic test_short_frame();
        clear_lists();
        m_addr = 0; m_max = i_max_addr; m_done = 1'b0;
        pulse(0);
        send_frame(16'($urandom), 10, 1);
        send_frame(16'h00FF, 18, 18);
        model_frame(16'h00FF);
        checks++;
        if (got_a.size() != 1 || got_a[0] !== exp_a[0] || got_d[0] !== exp_d[0]) begin
            errors++;
            $display("FAIL short_write writes=%0d addr=%0d data=%h expected 1 write addr=%0d data=%h",
                     got_a.size(), got_a[0], got_d[0], exp_a[0], exp_d[0]);
        end
        checks++;
        if (o_state !== 3'd1) begin
            errors++;
            $display("FAIL short_state state=%0d expected 1", o_state);
        end
    endtask

    task automatic test_async_reset();
        fork
            send_frame(16'($urandom), 18, 18);
            begin
                repeat (80) @(posedge i_clk);
                #1;
                checks++;
                if (o_state !== 3'd2) begin
                    errors++;
                    $display("FAIL areset_pre state=%0d expected 2", o_state);
                end
                @(posedge i_clk);
                #3;
                i_rst = 1'b1;
                clear_lists();
                #1;
                checks++;
                if ({o_state, o_sram_we, o_done, o_sram_addr, o_sram_data, o_end_addr} !== '0) begin
                    errors++;
                    $display("FAIL areset_now state=%0d we=%0b done=%0b addr=%0d data=%h end=%0d expected all 0",
                             o_state, o_sram_we, o_done, o_sram_addr, o_sram_data, o_end_addr);
                end
                repeat (3) @(posedge i_clk);
                #1;
                i_rst = 1'b0;
            end
        join
        repeat (20) @(posedge i_clk);
        #1;
        checks++;
        if (o_state !== 3'd0 || got_a.size() != 0) begin
            errors++;
            $display("FAIL areset_after state=%0d writes=%0d expected state=0 writes=0", o_state, got_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_memory();
        test_pause_resume();
        test_stop_in_write();
        test_short_frame();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
